physics_step_scheduler: RTL and testbench

- Sequences one physics step per frame across N_OBJ oriented-box registers.
- Drives a single shared collision_detector / box_box_resolver datapath by selecting one object pair at a time.
- Gates impulse accumulation for each pair, then issues one commit pulse that loads every obb_reg with its updated state.
- Sits between the frame tick (vsync edge) and the obb_reg / obb_updater bank.

---
 rtl/physics_step_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_physics_step_scheduler.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/physics_step_scheduler.sv
// physics_step_scheduler
// Runs one physics step per frame_tick: clears the impulse accumulators,
// walks every object pair (a<b) in lexicographic order through the shared
// collision/resolver datapath, gates accumulation per pair, then issues a
// single commit pulse to the obb_reg bank.
//
// Optional feature (macro OBJ_MASK_EN): adds obj_active[N_OBJ-1:0], latched
// on the starting tick; pairs touching an inactive object skip SETTLE and
// get one idle SAMPLE cycle (no accumulate, no count).
//
// Interface semantics: frame_tick is a single-cycle request accepted only in
// IDLE (otherwise it is dropped and flagged in sticky overrun); acc_clr,
// acc_en and commit are single-cycle strobes with no back-pressure, and busy
// is high from CLEAR through COMMIT inclusive.
module physics_step_scheduler #(
  parameter int N_OBJ         = 4,
  parameter int IDX_W         = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame_tick,
  input  logic             is_collision,
  input  logic             ignore_impulse,
`ifdef OBJ_MASK_EN
  input  logic [N_OBJ-1:0] obj_active,
`endif
  output logic [IDX_W-1:0] sel_a,
  output logic [IDX_W-1:0] sel_b,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             commit,
  output logic             busy,
  output logic [CNT_W-1:0] last_collisions,
  output logic             overrun,
  output logic [2:0]       dbg_state
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] sel_a_q, sel_a_d;
  logic [IDX_W-1:0] sel_b_q, sel_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SET_W-1:0] set_q, set_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic             ovr_q, ovr_d;

  // Pair sequencing helpers
  logic [IDX_W-1:0] nxt_a, nxt_b;
  logic             last_pair;
  logic             cur_active;
  logic             nxt_active;

`ifdef OBJ_MASK_EN
  logic [N_OBJ-1:0] mask_q, mask_d;

  // Active flags for the current and the following pair come from the latched mask
  always_comb begin
    cur_active = mask_q[sel_a_q] & mask_q[sel_b_q];
    nxt_active = mask_q[nxt_a] & mask_q[nxt_b];
  end

  // Object mask register, captured when a step starts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mask_q <= '1;
    else          mask_q <= mask_d;
  end
`else
  // Without the mask every pair takes part in the step
  always_comb begin
    cur_active = 1'b1;
    nxt_active = 1'b1;
  end
`endif

  // Successor of the current pair in lexicographic order
  always_comb begin
    nxt_a     = sel_a_q;
    nxt_b     = sel_b_q;
    last_pair = 1'b0;
    if (sel_b_q < IDX_W'(N_OBJ - 1)) begin
      nxt_b = sel_b_q + IDX_W'(1);
    end else if (sel_a_q < IDX_W'(N_OBJ - 2)) begin
      nxt_a = sel_a_q + IDX_W'(1);
      nxt_b = sel_a_q + IDX_W'(2);
    end else begin
      last_pair = 1'b1;
    end
  end

  // Next-state and strobe outputs of the step sequencer
  always_comb begin
    state_d = state_q;
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q;
    cnt_d   = cnt_q;
    set_d   = set_q;
    last_d  = last_q;
    ovr_d   = ovr_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    commit  = 1'b0;
`ifdef OBJ_MASK_EN
    mask_d  = mask_q;
`endif

    // A tick that cannot start a step is dropped and remembered
    if (frame_tick && (state_q != S_IDLE)) ovr_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          sel_a_d = '0;
          sel_b_d = IDX_W'(1);
          cnt_d   = '0;
          state_d = S_CLEAR;
`ifdef OBJ_MASK_EN
          mask_d  = obj_active;
`endif
        end
      end
      S_CLEAR: begin
        acc_clr = 1'b1;
        set_d   = '0;
        state_d = cur_active ? S_SETTLE : S_SAMPLE;
      end
      S_SETTLE: begin
        set_d = set_q + SET_W'(1);
        if (set_q == SET_W'(SETTLE_CYCLES - 1)) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        acc_en = cur_active & is_collision & ~ignore_impulse;
        if (cur_active && is_collision) cnt_d = cnt_q + CNT_W'(1);
        if (last_pair) begin
          state_d = S_COMMIT;
        end else begin
          sel_a_d = nxt_a;
          sel_b_d = nxt_b;
          set_d   = '0;
          state_d = nxt_active ? S_SETTLE : S_SAMPLE;
        end
      end
      S_COMMIT: begin
        commit  = 1'b1;
        last_d  = cnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any step without a commit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      sel_a_q <= '0;
      sel_b_q <= IDX_W'(1);
      cnt_q   <= '0;
      set_q   <= '0;
      last_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
      cnt_q   <= cnt_d;
      set_q   <= set_d;
      last_q  <= last_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sel_a           = sel_a_q;
  assign sel_b           = sel_b_q;
  assign busy            = (state_q != S_IDLE);
  assign last_collisions = last_q;
  assign overrun         = ovr_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_physics_step_scheduler.sv
// Testbench for physics_step_scheduler: randomized pair collision/veto
// patterns checked cycle by cycle against a step-schedule model.
module tb_physics_step_scheduler;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int S  = 2;
  localparam int CW = 8;
  localparam int P  = N * (N - 1) / 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          frame_tick = 1'b0;
  logic          is_collision;
  logic          ignore_impulse;
  logic [IW-1:0] sel_a, sel_b;
  logic          acc_clr, acc_en, commit, busy, overrun;
  logic [CW-1:0] last_collisions;
  logic [2:0]    dbg_state;
  logic [N-1:0]  obj_active = '1;

  // Detector/resolver stand-ins: per-pair truth tables indexed by {a,b}
  logic [15:0] coll_v = '0;
  logic [15:0] ign_v  = '0;
  assign is_collision   = coll_v[{sel_a, sel_b}];
  assign ignore_impulse = ign_v[{sel_a, sel_b}];

  physics_step_scheduler #(
    .N_OBJ(N), .IDX_W(IW), .SETTLE_CYCLES(S), .CNT_W(CW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .frame_tick     (frame_tick),
    .is_collision   (is_collision),
    .ignore_impulse (ignore_impulse),
`ifdef OBJ_MASK_EN
    .obj_active     (obj_active),
`endif
    .sel_a          (sel_a),
    .sel_b          (sel_b),
    .acc_clr        (acc_clr),
    .acc_en         (acc_en),
    .commit         (commit),
    .busy           (busy),
    .last_collisions(last_collisions),
    .overrun        (overrun),
    .dbg_state      (dbg_state)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model state that persists across steps
  int ovr_model  = 0;
  int last_model = 0;

  // Advance to 1 time unit after the next rising edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model + driver ----------------
  // Runs one step started now. over_at: cycle at which a stray tick is
  // driven (0 = none). rst_at: cycle at which reset is pulsed (0 = none).
  // Returns during the first idle cycle after the commit (or after reset).
  task automatic run_step(input logic [15:0] coll, input logic [15:0] ign,
                          input logic [N-1:0] mask, input int over_at,
                          input int rst_at);
    int pa[P], pb[P], samp[P];
    int t, k, commit_cyc, cnt, ea, eb;
    logic act, e_en;
    coll_v = coll;
    ign_v  = ign;
`ifdef OBJ_MASK_EN
    obj_active = mask;
`endif
    // Schedule: CLEAR at 1, then per pair SETTLE (if active) then one SAMPLE
    k = 0; t = 2; cnt = 0;
    for (int a = 0; a < N; a++)
      for (int b = a + 1; b < N; b++) begin
        act = mask[a] & mask[b];
        pa[k] = a; pb[k] = b;
        if (act) t += S;
        samp[k] = t;
        t++;
        if (act && coll[a*4+b]) cnt++;
        k++;
      end
    commit_cyc = t;

    frame_tick = 1'b1;
    next_cycle();
    frame_tick = 1'b0;
`ifdef OBJ_MASK_EN
    obj_active = ~mask;  // latched copy must be used, not the live input
`endif

    for (int c = 1; c <= commit_cyc + 1; c++) begin
      if (c == rst_at) begin
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || commit !== 1'b0 || overrun !== 1'b0 ||
            acc_en !== 1'b0 || last_collisions !== '0) begin
          miscompares++;
          $display("FAIL abort_reset c=%0d busy=%b commit=%b overrun=%b acc_en=%b last=%0d need 0", c, busy, commit, overrun, acc_en, last_collisions);
        end
        #2 reset_n = 1'b1;
        ovr_model = 0; last_model = 0;
        next_cycle();
        return;
      end
      frame_tick = (c == over_at);
      // Expected pair: first pair whose SAMPLE is not yet past
      k = P - 1;
      for (int j = P - 1; j >= 0; j--) if (samp[j] >= c) k = j;
      ea = pa[k]; eb = pb[k];
      e_en = 1'b0;
      for (int j = 0; j < P; j++)
        if (samp[j] == c && mask[pa[j]] && mask[pb[j]])
          e_en = coll[pa[j]*4+pb[j]] & ~ign[pa[j]*4+pb[j]];
      if (c > commit_cyc) last_model = cnt;

      vectors++;
      if (busy !== (c <= commit_cyc)) begin
        miscompares++;
        $display("FAIL busy c=%0d got %b need %b", c, busy, (c <= commit_cyc));
      end
      vectors++;
      if (acc_clr !== (c == 1)) begin
        miscompares++;
        $display("FAIL acc_clr c=%0d got %b need %b", c, acc_clr, (c == 1));
      end
      vectors++;
      if (commit !== (c == commit_cyc)) begin
        miscompares++;
        $display("FAIL commit c=%0d got %b need %b", c, commit, (c == commit_cyc));
      end
      vectors++;
      if (acc_en !== e_en) begin
        miscompares++;
        $display("FAIL acc_en c=%0d got %b need %b", c, acc_en, e_en);
      end
      if (c <= commit_cyc) begin
        vectors++;
        if (sel_a !== IW'(ea) || sel_b !== IW'(eb)) begin
          miscompares++;
          $display("FAIL select c=%0d got (%0d,%0d) need (%0d,%0d)", c, sel_a, sel_b, ea, eb);
        end
      end
      vectors++;
      if (overrun !== (ovr_model != 0)) begin
        miscompares++;
        $display("FAIL overrun c=%0d got %b need %0d", c, overrun, ovr_model);
      end
      vectors++;
      if (last_collisions !== CW'(last_model)) begin
        miscompares++;
        $display("FAIL last_collisions c=%0d got %0d need %0d", c, last_collisions, last_model);
      end
      if (c <= commit_cyc) begin
        next_cycle();
        frame_tick = 1'b0;
        if (c == over_at) ovr_model = 1;
      end
    end
  endtask

  // Idle for n cycles, confirming nothing starts on its own
  task automatic idle_cycles(input int n);
    frame_tick = 1'b0;
    for (int i = 0; i < n; i++) begin
      next_cycle();
      vectors++;
      if (busy !== 1'b0 || acc_clr !== 1'b0 || commit !== 1'b0) begin
        miscompares++;
        $display("FAIL idle busy=%b acc_clr=%b commit=%b need 0", busy, acc_clr, commit);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    frame_tick = 1'b1;
    repeat (3) next_cycle();
    vectors++;
    if (sel_a !== 2'd0 || sel_b !== 2'd1 || acc_clr !== 1'b0 || acc_en !== 1'b0 ||
        commit !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || last_collisions !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_values sel=(%0d,%0d) clr=%b en=%b commit=%b busy=%b ovr=%b last=%0d need (0,1) and zeros",
               sel_a, sel_b, acc_clr, acc_en, commit, busy, overrun, last_collisions);
    end
    frame_tick = 1'b0;
    #2 reset_n = 1'b1;
    idle_cycles(4);
  endtask

  task automatic test_no_collision();
    run_step(16'h0000, 16'h0000, '1, 0, 0);
    idle_cycles(2);
  endtask

  task automatic test_single_pair();
    logic [15:0] c;
    c = '0;
    c[1*4+3] = 1'b1;
    run_step(c, 16'h0000, '1, 0, 0);
    idle_cycles(2);
  endtask

  task automatic test_all_ignored();
    run_step(16'hFFFF, 16'hFFFF, '1, 0, 0);
    idle_cycles(2);
  endtask

  task automatic test_overrun_abort();
    run_step(16'($urandom), 16'($urandom), '1, 5, 0);
    idle_cycles(1);
    run_step(16'($urandom), 16'($urandom), '1, 0, 12);
    idle_cycles(1);
    run_step(16'($urandom), 16'($urandom), '1, 0, 0);
    idle_cycles(1);
  endtask

  // New step in the first idle cycle after commit; stray tick on the commit cycle
  task automatic test_back_to_back();
    run_step(16'($urandom), 16'($urandom), '1, 0, 0);
    run_step(16'($urandom), 16'($urandom), '1, 2 + P * (S + 1), 0);
    run_step(16'($urandom), 16'($urandom), '1, 0, 0);
    idle_cycles(1);
  endtask

  task automatic test_random();
    logic [N-1:0] m;
    int ov;
    for (int i = 0; i < 20; i++) begin
      m = '1;
`ifdef OBJ_MASK_EN
      m = N'($urandom);
`endif
      ov = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 10) : 0;
      run_step(16'($urandom), 16'($urandom), m, ov, 0);
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
    end
  endtask

`ifdef OBJ_MASK_EN
  task automatic test_mask();
    run_step(16'hFFFF, 16'h0000, 4'b1011, 0, 0);
    idle_cycles(1);
  endtask
`endif

  initial begin
    test_reset();
    test_no_collision();
    test_single_pair();
    test_all_ignored();
    test_overrun_abort();
    test_back_to_back();
`ifdef OBJ_MASK_EN
    test_mask();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time limit so the bench always ends
  initial begin
    #500000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1);
  end

endmodule
